// File: rtl/regfile_sb.sv
// Register file with N combinational read ports, one write port and a pending-write scoreboard.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wenable,
  input  logic [AW-1:0]       rd,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  input  logic                flush,
  output logic [AW:0]         busy_count
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_busy_count;
  logic [NREGS-1:0] w_busy_next;
  logic [AW:0]      w_count_next;
  logic             w_wr_en;

  assign w_wr_en = wenable && (rd != '0);

  // Issue is applied after writeback so a same-cycle issue to the same register wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_wr_en)
      w_busy_next[rd] = 1'b0;
    if (flush)
      w_busy_next = '0;
    else if (issue_valid && (issue_rd != '0))
      w_busy_next[issue_rd] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_comb begin
    w_count_next = '0;
    for (int i = 0; i < NREGS; i++)
      w_count_next = w_count_next + {{AW{1'b0}}, w_busy_next[i]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      if (w_wr_en)
        r_regs[rd] <= wdata;
      r_busy       <= w_busy_next;
      r_busy_count <= w_count_next;
    end
  end

  assign busy_count = r_busy_count;

  genvar gi;
  generate
    for (gi = 0; gi < NRP; gi++) begin : g_rport
      logic [AW-1:0]   w_ra;
      logic [XLEN-1:0] w_stored;
      assign w_ra     = raddr[gi*AW +: AW];
      assign w_stored = (w_ra == '0) ? '0 : r_regs[w_ra];
`ifdef REGFILE_BYPASS_EN
      logic w_fwd;
      assign w_fwd = w_wr_en && (w_ra == rd);
      assign rdata[gi*XLEN +: XLEN] = w_fwd ? wdata : w_stored;
      // A forwarded register only stays busy if it is being re-issued this same cycle.
      assign rbusy[gi] = w_fwd ? (issue_valid && !flush && (issue_rd == rd)) : r_busy[w_ra];
`else
      assign rdata[gi*XLEN +: XLEN] = w_stored;
      assign rbusy[gi] = r_busy[w_ra];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; expectations follow REGFILE_BYPASS_EN if defined.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRP = 2;
  localparam int AW = 5;

  logic                clk;
  logic                reset;
  logic                wenable;
  logic [AW-1:0]       rd;
  logic [XLEN-1:0]     wdata;
  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic [NRP-1:0]      rbusy;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic                flush;
  logic [AW:0]         busy_count;

  int checks = 0;
  int failures = 0;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) dut (
    .clk(clk), .reset(reset), .wenable(wenable), .rd(rd), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .flush(flush), .busy_count(busy_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int a0, input int a1);
    raddr = {AW'(a1), AW'(a0)};
    #1;
  endtask

  task automatic idle();
    wenable = 1'b0; rd = '0; wdata = '0;
    issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    raddr = '0;
    tick();
    tick();
    reset = 1'b0;

    // 1: everything reads zero after reset
    chk("rst_count", 64'(busy_count), 64'd0);
    for (int i = 0; i < NREGS; i++) begin
      set_ra(i, NREGS - 1 - i);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_rbusy", 64'(rbusy), 64'd0);
    end

    // 2: basic write / read, and x0 stays zero
    set_ra(5, 5);
    wenable = 1'b1; rd = 5'd5; wdata = 32'hAAAA5555;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x5_samecyc", 64'(rdata), {32'hAAAA5555, 32'hAAAA5555});
`else
    chk("x5_samecyc", 64'(rdata), 64'd0);
`endif
    tick();
    idle();
    #1;
    chk("x5_read", 64'(rdata), {32'hAAAA5555, 32'hAAAA5555});
    wenable = 1'b1; rd = 5'd0; wdata = 32'hFFFFFFFF;
    tick();
    idle();
    set_ra(0, 0);
    chk("x0_read", 64'(rdata), 64'd0);
    chk("x0_busy", 64'(rbusy), 64'd0);
    chk("x0_count", 64'(busy_count), 64'd0);

    // 3: issue, writeback, WAW, flush
    issue_valid = 1'b1; issue_rd = 5'd10;
    tick();
    issue_rd = 5'd11;
    tick();
    idle();
    set_ra(10, 11);
    chk("iss_count2", 64'(busy_count), 64'd2);
    chk("iss_rbusy", 64'(rbusy), 64'b11);
    wenable = 1'b1; rd = 5'd10; wdata = 32'h11112222;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("wb_fwd_busy", 64'(rbusy), 64'b10);
    chk("wb_fwd_data", 64'(rdata), {32'h0, 32'h11112222});
`else
    chk("wb_old_busy", 64'(rbusy), 64'b11);
    chk("wb_old_data", 64'(rdata), 64'd0);
`endif
    tick();
    idle();
    #1;
    chk("wb_count1", 64'(busy_count), 64'd1);
    chk("wb_rbusy", 64'(rbusy), 64'b10);
    chk("wb_rdata", 64'(rdata), {32'h0, 32'h11112222});
    issue_valid = 1'b1; issue_rd = 5'd11;
    tick();
    idle();
    #1;
    chk("waw_count", 64'(busy_count), 64'd1);
    chk("waw_rbusy", 64'(rbusy), 64'b10);
    flush = 1'b1;
    tick();
    idle();
    #1;
    chk("flush_count", 64'(busy_count), 64'd0);
    chk("flush_rbusy", 64'(rbusy), 64'd0);

    // 4: issue and write to the same register in the same cycle
    set_ra(7, 7);
    issue_valid = 1'b1; issue_rd = 5'd7;
    wenable = 1'b1; rd = 5'd7; wdata = 32'h12345678;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("iw_fwd_busy", 64'(rbusy), 64'b11);
    chk("iw_fwd_data", 64'(rdata), {32'h12345678, 32'h12345678});
`else
    chk("iw_old_busy", 64'(rbusy), 64'b00);
    chk("iw_old_data", 64'(rdata), 64'd0);
`endif
    tick();
    idle();
    #1;
    chk("iw_busy", 64'(rbusy), 64'b11);
    chk("iw_data", 64'(rdata), {32'h12345678, 32'h12345678});
    chk("iw_count", 64'(busy_count), 64'd1);

    // flush with a same-cycle issue drops the issue; same-cycle write still commits
    set_ra(8, 12);
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd8;
    wenable = 1'b1; rd = 5'd12; wdata = 32'h0BADF00D;
    tick();
    idle();
    #1;
    chk("fi_count", 64'(busy_count), 64'd0);
    chk("fi_rbusy", 64'(rbusy), 64'd0);
    chk("fi_wdata", 64'(rdata), {32'h0BADF00D, 32'h0});

    // 5: read during the write edge, then after it
    wenable = 1'b1; rd = 5'd9; wdata = 32'h00000001;
    tick();
    idle();
    set_ra(9, 9);
    wenable = 1'b1; rd = 5'd9; wdata = 32'hCAFEF00D;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_data", 64'(rdata), {32'hCAFEF00D, 32'hCAFEF00D});
`else
    chk("byp_data", 64'(rdata), {32'h00000001, 32'h00000001});
`endif
    tick();
    idle();
    #1;
    chk("byp_next", 64'(rdata), {32'hCAFEF00D, 32'hCAFEF00D});

    // 6: reset in the middle of activity wins over write and issue
    issue_valid = 1'b1; issue_rd = 5'd1;
    tick();
    issue_rd = 5'd2;
    tick();
    issue_rd = 5'd3; wenable = 1'b1; rd = 5'd3; wdata = 32'hDEADBEEF;
    tick();
    idle();
    set_ra(3, 1);
    chk("pre_count", 64'(busy_count), 64'd3);
    chk("pre_rbusy", 64'(rbusy), 64'b11);
    chk("pre_x3", 64'(rdata), {32'h0, 32'hDEADBEEF});
    reset = 1'b1;
    wenable = 1'b1; rd = 5'd4; wdata = 32'h55555555;
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("mr_count", 64'(busy_count), 64'd0);
    chk("mr_x3", 64'(rdata), 64'd0);
    set_ra(4, 5);
    chk("mr_x4x5", 64'(rdata), 64'd0);
    chk("mr_rbusy", 64'(rbusy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
